// File: rtl/reglk_ctrl.sv
// Register-lock controller: a bank of self-locking registers plus a JTAG
// challenge/response FSM that opens a timed window in which the locks may be overwritten.
module reglk_ctrl #(
    parameter int          NUM_REGS      = 6,
    parameter int          DATA_W        = 32,
    parameter logic [63:0] UNLOCK_KEY    = 64'h0000_0000_A5A5_5A5A,
    parameter int          KEY_TIMEOUT   = 8,
    parameter int          UNLOCK_WINDOW = 16,
    parameter int          MAX_FAIL      = 3,
    localparam int         ADDR_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic [DATA_W-1:0]                wdata_i,
    input  logic                             clear_req_i,
    input  logic                             jtag_unlock_i,
    input  logic                             jtag_key_valid_i,
    input  logic [DATA_W-1:0]                jtag_key_i,
    input  logic                             jtag_relock_i,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  reglk_mem_o,
    output logic                             wr_ack_o,
    output logic                             wr_err_o,
    output logic                             unlocked_o,
    output logic                             lockout_o
);

    localparam int CNT_MAX = (KEY_TIMEOUT > UNLOCK_WINDOW) ? KEY_TIMEOUT : UNLOCK_WINDOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam logic [DATA_W-1:0] KEY = UNLOCK_KEY[DATA_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHALLENGE,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t                            r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic [FAIL_W-1:0]                 r_failCnt;
    logic [NUM_REGS-1:0][DATA_W-1:0]   r_mem;
    logic                              r_ack;
    logic                              r_err;

    logic                              w_unlocked;
    logic                              w_lastCycle;
    logic [FAIL_W-1:0]                 w_failNext;
    logic                              w_addrOk;
    logic [DATA_W-1:0]                 w_curWord;
    logic [DATA_W-1:0]                 w_newWord;
    logic                              w_writeOk;

    assign w_unlocked  = (r_state == S_UNLOCKED);
    assign w_lastCycle = (r_cnt <= CNT_W'(1));
    assign w_failNext  = (r_failCnt == FAIL_W'(MAX_FAIL)) ? r_failCnt : r_failCnt + FAIL_W'(1);

    always_comb begin
        w_addrOk  = 1'b0;
        w_curWord = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_i == ADDR_W'(i)) begin
                w_addrOk  = 1'b1;
                w_curWord = r_mem[i];
            end
        end
    end

    // Inside the window writes overwrite; outside they may only set bits of an unlocked word.
    assign w_newWord = w_unlocked ? wdata_i : (w_curWord | wdata_i);
    assign w_writeOk = w_addrOk && (w_unlocked || !w_curWord[0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_failCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (jtag_unlock_i) begin
                        r_state <= S_CHALLENGE;
                        r_cnt   <= CNT_W'(KEY_TIMEOUT);
                    end
                end
                S_CHALLENGE: begin
                    if (jtag_key_valid_i && (jtag_key_i == KEY)) begin
                        r_state   <= S_UNLOCKED;
                        r_failCnt <= '0;
                        r_cnt     <= CNT_W'(UNLOCK_WINDOW);
                    end else if (jtag_key_valid_i || w_lastCycle) begin
                        r_cnt     <= '0;
                        r_failCnt <= w_failNext;
                        r_state   <= (w_failNext == FAIL_W'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_UNLOCKED: begin
                    if (jtag_relock_i || w_lastCycle) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LOCKOUT: r_state <= S_LOCKOUT;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Clear outranks a same-cycle write, so exactly one ack/err pulse results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (clear_req_i) begin
                if (w_unlocked) begin
                    r_mem <= '0;
                    r_ack <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (we_i) begin
                if (w_writeOk) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_i == ADDR_W'(i)) begin
                            r_mem[i] <= w_newWord;
                        end
                    end
                    r_ack <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign reglk_mem_o = r_mem;
    assign wr_ack_o    = r_ack;
    assign wr_err_o    = r_err;
    assign unlocked_o  = w_unlocked;
    assign lockout_o   = (r_state == S_LOCKOUT);

endmodule

// File: tb/tb_reglk_ctrl.sv
// Directed bench for reglk_ctrl: expected ack/err and register contents are queued
// when each request is issued and checked by a monitor when the pulse appears.
module tb_reglk_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              we_i;
    logic [2:0]        addr_i;
    logic [31:0]       wdata_i;
    logic              clear_req_i;
    logic              jtag_unlock_i;
    logic              jtag_key_valid_i;
    logic [31:0]       jtag_key_i;
    logic              jtag_relock_i;
    logic [5:0][31:0]  reglk_mem_o;
    logic              wr_ack_o;
    logic              wr_err_o;
    logic              unlocked_o;
    logic              lockout_o;

    typedef struct {
        logic        isAck;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   passCount  = 0;

    reglk_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .clear_req_i      (clear_req_i),
        .jtag_unlock_i    (jtag_unlock_i),
        .jtag_key_valid_i (jtag_key_valid_i),
        .jtag_key_i       (jtag_key_i),
        .jtag_relock_i    (jtag_relock_i),
        .reglk_mem_o      (reglk_mem_o),
        .wr_ack_o         (wr_ack_o),
        .wr_err_o         (wr_err_o),
        .unlocked_o       (unlocked_o),
        .lockout_o        (lockout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                                 input logic clr, input logic unl, input logic kv,
                                 input logic [31:0] key, input logic rel);
        we_i = we; addr_i = addr; wdata_i = wdata; clear_req_i = clr;
        jtag_unlock_i = unl; jtag_key_valid_i = kv; jtag_key_i = key; jtag_relock_i = rel;
        tick();
        we_i = 1'b0; addr_i = '0; wdata_i = '0; clear_req_i = 1'b0;
        jtag_unlock_i = 1'b0; jtag_key_valid_i = 1'b0; jtag_key_i = '0; jtag_relock_i = 1'b0;
    endtask

    task automatic doWrite(input logic [2:0] addr, input logic [31:0] data,
                           input logic isAck, input int idx, input logic [31:0] val);
        sbQueue.push_back('{isAck, idx, val});
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic doClear(input logic withWe, input logic isAck, input logic [31:0] val);
        sbQueue.push_back('{isAck, -1, val});
        applyStimulus(withWe, 3'd1, 32'h55, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic unlockWithKey(input int waitCycles, input logic [31:0] key);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        repeat (waitCycles) tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, key, 1'b0);
    endtask

    task automatic pulseReset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // Monitor: every ack/err pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (wr_ack_o || wr_err_o) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedPulse", {62'd0, wr_ack_o, wr_err_o}, 64'd0);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("pulseKind", {62'd0, wr_ack_o, wr_err_o}, e.isAck ? 64'd2 : 64'd1);
                if (e.idx < 0) begin
                    for (int i = 0; i < 6; i++) checkOutput("memAll", 64'(reglk_mem_o[i]), 64'(e.val));
                end else begin
                    checkOutput("memWord", 64'(reglk_mem_o[e.idx]), 64'(e.val));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0; clear_req_i = 1'b0;
        jtag_unlock_i = 1'b0; jtag_key_valid_i = 1'b0; jtag_key_i = '0; jtag_relock_i = 1'b0;
        repeat (3) tick();
        checkOutput("rstUnlocked", 64'(unlocked_o), 64'd0);
        checkOutput("rstLockout", 64'(lockout_o), 64'd0);
        checkOutput("rstPulses", {62'd0, wr_ack_o, wr_err_o}, 64'd0);
        for (int i = 0; i < 6; i++) checkOutput("rstMem", 64'(reglk_mem_o[i]), 64'd0);
        rst_i = 1'b0;

        doWrite(3'd2, 32'h10, 1'b1, 2, 32'h10);
        doWrite(3'd2, 32'h01, 1'b1, 2, 32'h11);
        doWrite(3'd2, 32'h00, 1'b0, 2, 32'h11);

        // Unlock window: entry edge, 15 more cycles still open, the 16th closes it.
        doWrite(3'd0, 32'h01, 1'b1, 0, 32'h01);
        unlockWithKey(2, KEY);
        checkOutput("unlockEntry", 64'(unlocked_o), 64'd1);
        doWrite(3'd0, 32'h00, 1'b1, 0, 32'h00);
        repeat (14) tick();
        checkOutput("windowStillOpen", 64'(unlocked_o), 64'd1);
        doWrite(3'd2, 32'h20, 1'b1, 2, 32'h20);
        checkOutput("windowClosed", 64'(unlocked_o), 64'd0);

        for (int i = 0; i < 6; i++) doWrite(3'(i), 32'hFF, 1'b1, i, 32'hFF);
        doClear(1'b0, 1'b0, 32'hFF);
        unlockWithKey(0, KEY);
        checkOutput("unlockFirstCycle", 64'(unlocked_o), 64'd1);
        doClear(1'b1, 1'b1, 32'h0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("relock", 64'(unlocked_o), 64'd0);

        // Key timeout boundary: key on the 8th challenge cycle wins, one cycle later it does not.
        unlockWithKey(7, KEY);
        checkOutput("keyLastCycle", 64'(unlocked_o), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("relock2", 64'(unlocked_o), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        repeat (8) tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, KEY, 1'b0);
        checkOutput("keyAfterTimeout", 64'(unlocked_o), 64'd0);
        doWrite(3'd6, 32'h01, 1'b0, -1, 32'h0);
        unlockWithKey(0, 32'h0);
        checkOutput("failTwoNoLockout", 64'(lockout_o), 64'd0);
        unlockWithKey(0, 32'h0);
        checkOutput("failThreeLockout", 64'(lockout_o), 64'd1);
        unlockWithKey(0, KEY);
        checkOutput("lockoutKeyIgnored", 64'(unlocked_o), 64'd0);
        checkOutput("lockoutHeld", 64'(lockout_o), 64'd1);
        doWrite(3'd3, 32'h04, 1'b1, 3, 32'h04);
        pulseReset();
        checkOutput("rstClearsLockout", 64'(lockout_o), 64'd0);
        checkOutput("rstClearsMem3", 64'(reglk_mem_o[3]), 64'd0);

        for (int n = 0; n < 3; n++) begin
            unlockWithKey(0, 32'h0);
            checkOutput("wrongKeyLockout", 64'(lockout_o), (n == 2) ? 64'd1 : 64'd0);
        end
        unlockWithKey(0, KEY);
        checkOutput("lockoutRejectsKey", 64'(unlocked_o), 64'd0);
        pulseReset();
        checkOutput("rstExitsLockout", 64'(lockout_o), 64'd0);

        doWrite(3'd1, 32'h03, 1'b1, 1, 32'h03);
        unlockWithKey(1, KEY);
        checkOutput("unlockBeforeRst", 64'(unlocked_o), 64'd1);
        rst_i = 1'b1; we_i = 1'b1; addr_i = 3'd1; wdata_i = 32'h08;
        tick();
        rst_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        checkOutput("rstInUnlocked", 64'(unlocked_o), 64'd0);
        checkOutput("rstNoPulse", {62'd0, wr_ack_o, wr_err_o}, 64'd0);
        for (int i = 0; i < 6; i++) checkOutput("rstMemUnlocked", 64'(reglk_mem_o[i]), 64'd0);

        repeat (3) tick();
        checkOutput("sbDrained", 64'(sbQueue.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
